// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/half/word loads and stores against a
// single-ported DataMemory. The memory reads combinationally and writes on the
// rising clock edge.
// Sub-word stores are done as read-modify-write: MERGE reads the word, then
// WRITE stores it back.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half and
// word accesses. By default, misaligned low address bits are ignored.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_writeEnable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  input  logic [31:0] mem_readData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MERGE,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] resp_rdata_q;
  logic        resp_error_q;

  logic        funct3_legal;
  logic        out_of_range;
  logic        misaligned;
  logic        err_d;
  logic [31:0] lane_shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_d;
  logic [31:0] merge_d;

  // Classify the request on the input port so IDLE can choose its next state.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    funct3_legal = 1'b0;
    misaligned   = 1'b0;
    if (req_write) funct3_legal = req_funct3 inside {F3_B, F3_H, F3_W};
    else           funct3_legal = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    out_of_range = {1'b0, req_addr} >= ADDR_LIMIT;
`ifdef LSU_ALIGN_CHECK_EN
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
`endif
    err_d = !funct3_legal || out_of_range || misaligned;
  end

  // Extract and extend the load lane, and build the merged word for SB/SH.
  always_comb begin
    lane_shifted = mem_readData >> {addr_q[1:0], 3'b000};
    byte_sel     = lane_shifted[7:0];
    half_sel     = addr_q[1] ? mem_readData[31:16] : mem_readData[15:0];
    case (funct3_q)
      F3_B:    load_d = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_d = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_d = {24'd0, byte_sel};
      F3_HU:   load_d = {16'd0, half_sel};
      default: load_d = mem_readData;
    endcase
    merge_d = mem_readData;
    if (funct3_q[1:0] == 2'b00) merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                        merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Request sequencer: captures the request, steps through the access, and holds the response.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q       <= req_addr;
            funct3_q     <= req_funct3;
            wdata_q      <= req_wdata;
            write_q      <= req_write;
            resp_rdata_q <= '0;
            resp_error_q <= err_d;
            if (err_d)                   state_q <= S_RESP;
            else if (!req_write)         state_q <= S_LOAD;
            else if (req_funct3 == F3_W) state_q <= S_WRITE;
            else                         state_q <= S_MERGE;
          end
        end
        S_LOAD: begin
          resp_rdata_q <= load_d;
          state_q      <= S_RESP;
        end
        S_MERGE: begin
          wdata_q <= merge_d;
          state_q <= S_WRITE;
        end
        S_WRITE: state_q <= S_RESP;
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the registered state. The write strobe is also
  // gated by reset, so a reset that arrives during WRITE suppresses the write.
  always_comb begin
    req_ready       = (state_q == S_IDLE);
    resp_valid      = (state_q == S_RESP);
    resp_rdata      = resp_rdata_q;
    resp_error      = resp_error_q;
    mem_address     = '0;
    if (state_q inside {S_LOAD, S_MERGE, S_WRITE}) mem_address = {addr_q[31:2], 2'b00};
    mem_writeEnable = (state_q == S_WRITE) && !rst;
    mem_writeData   = (state_q == S_WRITE && write_q) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit. It contains a DataMemory, a transaction-level
// model with its own shadow memory, and one per-cycle compare process. Directed
// requests also have hand-computed literal results.
module tb_load_store_unit;

  localparam int MW = 64;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_writeEnable;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;

  logic [31:0] dmem    [MW];
  logic [31:0] ref_mem [MW];

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    chk_en = 1'b0;
  bit    exp_busy [int];
  resp_t exp_resp [int];
  wr_t   exp_wr   [int];
  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .mem_writeEnable (mem_writeEnable),
    .mem_address     (mem_address),
    .mem_writeData   (mem_writeData),
    .mem_readData    (mem_readData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DataMemory: combinational read, write on the rising edge.
  assign mem_readData = dmem[mem_address[7:2]];
  always @(posedge clk) if (mem_writeEnable) dmem[mem_address[7:2]] <= mem_writeData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: result, latency and memory effect of one request.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output bit err, output logic [31:0] rdata,
                       output int lat, output bit wr, output logic [31:0] wword);
    bit          legal;
    int          idx;
    int          sh;
    logic [31:0] word;
    logic [7:0]  bv;
    logic [15:0] hv;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err   = !legal || (64'(a) >= 64'(4 * MW));
`ifdef LSU_ALIGN_CHECK_EN
    if (legal && (f3 % 4) == 1 && (a % 2) != 0) err = 1'b1;
    if (legal && (f3 % 4) == 2 && (a % 4) != 0) err = 1'b1;
`endif
    rdata = '0;
    wr    = 1'b0;
    wword = '0;
    lat   = 1;
    if (!err) begin
      idx  = int'(a / 4);
      word = ref_mem[idx];
      if (!w) begin
        lat = 2;
        bv  = 8'(word >> (8 * (a % 4)));
        hv  = 16'(word >> (16 * ((a / 2) % 2)));
        case (f3)
          3'd0:    rdata = 32'($signed(bv));
          3'd1:    rdata = 32'($signed(hv));
          3'd4:    rdata = 32'(bv);
          3'd5:    rdata = 32'(hv);
          default: rdata = word;
        endcase
      end else begin
        wr  = 1'b1;
        lat = (f3 == 3'd2) ? 2 : 3;
        case (f3)
          3'd0: begin
            sh    = 8 * int'(a % 4);
            wword = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
          end
          3'd1: begin
            sh    = 16 * int'((a / 2) % 2);
            wword = (word & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
          end
          default: wword = d;
        endcase
        ref_mem[idx] = wword;
      end
    end
  endtask

  // Issue one request at a falling edge, schedule the expected per-cycle
  // behaviour, and drive noise on req_* while the unit is busy.
  task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bit          err;
    bit          wr;
    logic [31:0] rdata;
    logic [31:0] wword;
    int          lat;
    int          acc;
    model(w, f3, a, d, err, rdata, lat, wr, wword);
    acc = cyc + 1;
    for (int k = 0; k < lat; k++) exp_busy[acc + k] = 1'b1;
    exp_resp[acc + lat - 1] = '{err: err, rdata: rdata};
    if (wr) exp_wr[acc + lat - 2] = '{addr: {a[31:2], 2'b00}, data: wword};
    last_rdata = 'x;
    last_err   = 'x;
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(negedge clk);
    for (int k = 0; k < lat; k++) begin
      req_valid  = 1'b1;
      req_write  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom_range(0, 255);
      req_wdata  = $urandom;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Per-cycle comparison of the DUT outputs against the scheduled expectations.
  always @(negedge clk) begin
    int c;
    c = cyc;
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(!exp_busy.exists(c)));
      check("resp_valid", 32'(resp_valid), 32'(exp_resp.exists(c)));
      if (exp_resp.exists(c) && resp_valid) begin
        check("resp_rdata", resp_rdata, exp_resp[c].rdata);
        check("resp_error", 32'(resp_error), 32'(exp_resp[c].err));
        last_rdata = resp_rdata;
        last_err   = resp_error;
      end
      check("mem_writeEnable", 32'(mem_writeEnable), 32'(exp_wr.exists(c)));
      if (exp_wr.exists(c) && mem_writeEnable) begin
        check("mem_address", mem_address, exp_wr[c].addr);
        check("mem_writeData", mem_writeData, exp_wr[c].data);
        last_wr_addr = mem_address;
        last_wr_data = mem_writeData;
      end
      if (!exp_busy.exists(c)) begin
        check("idle_mem_address", mem_address, 32'h0);
        check("idle_mem_writeData", mem_writeData, 32'h0);
      end
    end
  end

  initial begin
    for (int i = 0; i < MW; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_error", 32'(resp_error), 32'h0);
    check("rst_mem_we", 32'(mem_writeEnable), 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_writeData", mem_writeData, 32'h0);
    chk_en = 1'b1;
    @(negedge clk);

    // A word store followed by a word load of the same address.
    issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    check("sw8_wr_addr", last_wr_addr, 32'h8);
    check("sw8_wr_data", last_wr_data, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    check("lw8", last_rdata, 32'hDEADBEEF);

    // A byte store merged into the word, then sign-extended byte loads.
    issue(1'b1, 3'b000, 32'h9, 32'h12);
    check("sb9_wr_data", last_wr_data, 32'hDEAD12EF);
    issue(1'b0, 3'b000, 32'h9, 32'h0);
    check("lb9", last_rdata, 32'h00000012);
    issue(1'b0, 3'b000, 32'hB, 32'h0);
    check("lbB", last_rdata, 32'hFFFFFFDE);
    issue(1'b0, 3'b100, 32'hB, 32'h0);
    check("lbuB", last_rdata, 32'h000000DE);

    // Halfword loads of the upper half, zero- and sign-extended.
    issue(1'b0, 3'b101, 32'hA, 32'h0);
    check("lhuA", last_rdata, 32'h0000DEAD);
    issue(1'b0, 3'b001, 32'hA, 32'h0);
    check("lhA", last_rdata, 32'hFFFFDEAD);

    // A halfword store to the upper half, read back as a word.
    issue(1'b1, 3'b001, 32'hE, 32'hCAFE8001);
    issue(1'b0, 3'b010, 32'hC, 32'h0);
    check("lwC_after_sh", last_rdata, 32'h80010000);

    // A misaligned word load: rejected with the check enabled, otherwise it reads word 0x4.
    issue(1'b1, 3'b010, 32'h4, 32'h11223344);
    issue(1'b0, 3'b010, 32'h6, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    check("lw6_err", 32'(last_err), 32'h1);
    check("lw6_rdata", last_rdata, 32'h0);
`else
    check("lw6_err", 32'(last_err), 32'h0);
    check("lw6_rdata", last_rdata, 32'h11223344);
`endif
    issue(1'b0, 3'b001, 32'h7, 32'h0);

    // Illegal funct3 codes and an out-of-range address.
    issue(1'b0, 3'b011, 32'h8, 32'h0);
    check("f3_011_err", 32'(last_err), 32'h1);
    check("f3_011_rdata", last_rdata, 32'h0);
    issue(1'b1, 3'b100, 32'h8, 32'hFFFFFFFF);
    check("st_f3_100_err", 32'(last_err), 32'h1);
    issue(1'b0, 3'b010, 32'(4 * MW), 32'h0);
    check("oor_err", 32'(last_err), 32'h1);
    issue(1'b1, 3'b010, 32'(4 * MW - 4), 32'hA5A5_0F0F);
    issue(1'b0, 3'b010, 32'(4 * MW - 4), 32'h0);
    check("last_word", last_rdata, 32'hA5A50F0F);
    check("last_word_err", 32'(last_err), 32'h0);

    // Reset asserted during the WRITE cycle of SB 0x4: no write and no response.
    chk_en     = 1'b0;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h4;
    req_wdata  = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("sb4_in_write", 32'(mem_writeEnable), 32'h1);
    rst = 1'b1;
    #1;
    check("sb4_we_gated", 32'(mem_writeEnable), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("sb4_rst_no_resp", 32'(resp_valid), 32'h0);
    check("sb4_rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("sb4_after_no_resp", 32'(resp_valid), 32'h0);
    check("sb4_mem_kept", dmem[1], 32'h11223344);
    chk_en = 1'b1;
    issue(1'b0, 3'b010, 32'h4, 32'h0);
    check("lw4_after_rst", last_rdata, 32'h11223344);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
